reg_bus_demux: RTL and testbench

REG_BUS_DEMUX -- requirements
Module: reg_bus_demux

---
 rtl/reg_bus_demux.sv | 171 +++++++++++++++++
 tb/tb_reg_bus_demux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_demux.sv
// Register-bus demultiplexer: routes one master request to an address-decoded slave,
// waits for its ready (with optional timeout) and returns a one-cycle response.
module reg_bus_demux #(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_SLAVES      = 4,
    parameter int unsigned SLAVE_ADDR_BITS = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [ADDR_WIDTH-1:0]            mst_addr_i,
    input  logic                             mst_write_i,
    input  logic [DATA_WIDTH-1:0]            mst_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          mst_wstrb_i,
    input  logic                             mst_valid_i,
    output logic [DATA_WIDTH-1:0]            mst_rdata_o,
    output logic                             mst_error_o,
    output logic                             mst_ready_o,
    output logic [ADDR_WIDTH-1:0]            slv_addr_o,
    output logic                             slv_write_o,
    output logic [DATA_WIDTH-1:0]            slv_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          slv_wstrb_o,
    output logic [NUM_SLAVES-1:0]            slv_valid_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]            slv_error_i,
    input  logic [NUM_SLAVES-1:0]            slv_ready_i,
    output logic                             timeout_o
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned IdxW  = ADDR_WIDTH - SLAVE_ADDR_BITS;
    localparam int unsigned SelW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CntW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StFwd, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]        wstrb_q, wstrb_d;
    logic [NUM_SLAVES-1:0]   valid_q, valid_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    timeout_q, timeout_d;

    logic [IdxW-1:0]         idx;
    logic                    hit;
    logic                    sel_ready;
    logic                    sel_error;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    assign idx = mst_addr_i[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
    assign hit = (32'(idx) < NUM_SLAVES);

    // Only the selected slave's response is looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_error = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SelW'(k)) begin
                sel_ready = slv_ready_i[k];
                sel_error = slv_error_i[k];
                sel_rdata = slv_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mst_valid_i) begin
                    addr_d  = mst_addr_i;
                    write_d = mst_write_i;
                    wdata_d = mst_wdata_i;
                    wstrb_d = mst_wstrb_i;
                    cnt_d   = '0;
                    if (hit) begin
                        sel_d              = idx[SelW-1:0];
                        valid_d            = '0;
                        valid_d[idx[SelW-1:0]] = 1'b1;
                        state_d            = StFwd;
                    end else begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StFwd: begin
                // A ready in the expiry cycle takes priority over the timeout.
                if (sel_ready) begin
                    valid_d = '0;
                    rdata_d = sel_rdata;
                    error_d = sel_error;
                    state_d = StResp;
                end else if (TIMEOUT_CYCLES != 0 && 32'(cnt_q) == TIMEOUT_CYCLES - 1) begin
                    valid_d   = '0;
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            valid_q   <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    // Response registers are cleared on leaving RESP, so they read 0 elsewhere.
    assign mst_ready_o = (state_q == StResp);
    assign mst_rdata_o = rdata_q;
    assign mst_error_o = error_q;
    assign timeout_o   = timeout_q;
    assign slv_addr_o  = addr_q;
    assign slv_write_o = write_q;
    assign slv_wdata_o = wdata_q;
    assign slv_wstrb_o = wstrb_q;
    assign slv_valid_o = valid_q;

endmodule

// File: tb/tb_reg_bus_demux.sv
// Scoreboard bench for reg_bus_demux: a behavioural slave model answers requests and a
// monitor checks each master response against the queued expectation.
module tb_reg_bus_demux;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    mst_addr_i;
    logic             mst_write_i;
    logic [DW-1:0]    mst_wdata_i;
    logic [DW/8-1:0]  mst_wstrb_i;
    logic             mst_valid_i;
    logic [DW-1:0]    mst_rdata_o;
    logic             mst_error_o;
    logic             mst_ready_o;
    logic [AW-1:0]    slv_addr_o;
    logic             slv_write_o;
    logic [DW-1:0]    slv_wdata_o;
    logic [DW/8-1:0]  slv_wstrb_o;
    logic [NS-1:0]    slv_valid_o;
    logic [NS*DW-1:0] slv_rdata_i;
    logic [NS-1:0]    slv_error_i;
    logic [NS-1:0]    slv_ready_i;
    logic             timeout_o;

    reg_bus_demux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLAVE_ADDR_BITS(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mst_addr_i(mst_addr_i), .mst_write_i(mst_write_i), .mst_wdata_i(mst_wdata_i),
        .mst_wstrb_i(mst_wstrb_i), .mst_valid_i(mst_valid_i),
        .mst_rdata_o(mst_rdata_o), .mst_error_o(mst_error_o), .mst_ready_o(mst_ready_o),
        .slv_addr_o(slv_addr_o), .slv_write_o(slv_write_o), .slv_wdata_o(slv_wdata_o),
        .slv_wstrb_o(slv_wstrb_o), .slv_valid_o(slv_valid_o),
        .slv_rdata_i(slv_rdata_i), .slv_error_i(slv_error_i), .slv_ready_i(slv_ready_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Slave model: cfg_wait < 0 means never ready.
    int          cfg_wait [NS];
    logic [31:0] cfg_rdata[NS];
    logic        cfg_err  [NS];
    logic        noise_en = 1'b0;
    int          wcnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        slv_ready_i = {3'b000, noise_en};
        slv_error_i = '1;
        for (int k = 0; k < NS; k++) slv_rdata_i[k*DW +: DW] = cfg_rdata[k];
        if (slv_valid_o == '0) begin
            wcnt = 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (slv_valid_o[k]) begin
                    slv_error_i[k] = cfg_err[k];
                    slv_ready_i[k] = (cfg_wait[k] == wcnt);
                end
            end
            wcnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mst_ready_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("resp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("resp_rdata", mst_rdata_o, e.rdata);
                    check_eq("resp_error", mst_error_o, e.err);
                    check_eq("resp_timeout", timeout_o, e.to);
                end
            end else begin
                check_eq("idle_outputs", {mst_rdata_o, mst_error_o, timeout_o}, 0);
            end
        end
    end

    task automatic run_txn(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
        int   idx;
        bit   hit;
        bit   to;
        int   w;
        int   lat;
        int   vcnt;
        int   stab;
        exp_t e;
        idx = int'(addr[7:4]);
        hit = (idx < NS);
        w   = hit ? cfg_wait[idx] : 0;
        to  = hit && (w < 0 || w >= TO);
        e.rdata = (!hit || to) ? 32'h0 : cfg_rdata[idx];
        e.err   = (!hit || to) ? 1'b1 : cfg_err[idx];
        e.to    = to;
        exp_q.push_back(e);

        mst_addr_i  = addr;
        mst_write_i = wr;
        mst_wdata_i = wdata;
        mst_wstrb_i = wstrb;
        mst_valid_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("slv_valid_onehot", slv_valid_o, hit ? (4'b0001 << idx) : 4'b0000);
        check_eq("slv_request", {slv_addr_o, slv_write_o, slv_wstrb_o}, {addr, wr, wstrb});
        check_eq("slv_wdata", slv_wdata_o, wdata);
        lat  = 1;
        vcnt = 0;
        stab = 0;
        while (!mst_ready_o && lat < 64) begin
            if (slv_valid_o != '0) vcnt++;
            if ({slv_addr_o, slv_write_o, slv_wdata_o, slv_wstrb_o} !== {addr, wr, wdata, wstrb})
                stab++;
            // Junk on the master side must be ignored while busy.
            mst_addr_i  = 8'($urandom);
            mst_wdata_i = $urandom;
            mst_write_i = 1'($urandom);
            mst_wstrb_i = 4'($urandom);
            mst_valid_i = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("ready_seen", mst_ready_o, 1);
        check_eq("latency", lat, !hit ? 1 : (to ? TO + 1 : w + 2));
        check_eq("valid_cycles", vcnt, !hit ? 0 : (to ? TO : w + 1));
        check_eq("req_stable", stab, 0);
        check_eq("valid_dropped", slv_valid_o, 0);
        @(posedge clk);
        #1;
        check_eq("ready_pulse", mst_ready_o, 0);
        mst_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NS; k++) begin
            cfg_wait[k]  = 0;
            cfg_rdata[k] = 32'hA5A5_0000 + k;
            cfg_err[k]   = 1'b0;
        end
        rst         = 1'b1;
        mst_addr_i  = '0;
        mst_write_i = 1'b0;
        mst_wdata_i = '0;
        mst_wstrb_i = '0;
        mst_valid_i = 1'b0;
        #1;
        check_eq("reset_outputs",
                 {slv_valid_o, mst_ready_o, timeout_o, mst_error_o, slv_addr_o, slv_write_o}, 0);
        check_eq("reset_rdata", mst_rdata_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Read hit, zero-wait slave 2.
        cfg_wait[2] = 0; cfg_rdata[2] = 32'hDEAD_BEEF; cfg_err[2] = 1'b0;
        run_txn(8'h23, 1'b0, 32'h0, 4'hF);

        // Write with partial strobe, slave 1 after 3 waits returning error.
        cfg_wait[1] = 3; cfg_rdata[1] = 32'hCAFE_0001; cfg_err[1] = 1'b1;
        run_txn(8'h15, 1'b1, 32'h1234_5678, 4'b0011);

        // Decode miss.
        run_txn(8'h40, 1'b0, 32'h0, 4'hF);

        // Slave 3 never ready, then ready exactly in the expiry cycle.
        cfg_wait[3] = -1;
        run_txn(8'h37, 1'b0, 32'h0, 4'hF);
        cfg_wait[3] = TO - 1; cfg_rdata[3] = 32'h0BAD_F00D; cfg_err[3] = 1'b0;
        run_txn(8'h38, 1'b0, 32'h0, 4'hF);

        // Stray ready from slave 0 while slave 2 is selected.
        noise_en = 1'b1; cfg_rdata[0] = 32'hFFFF_0000; cfg_wait[2] = 2;
        cfg_rdata[2] = 32'h2222_2222;
        run_txn(8'h2C, 1'b0, 32'h0, 4'hF);
        noise_en = 1'b0;

        // Reset in the middle of a forward.
        cfg_wait[3]  = -1;
        mst_addr_i   = 8'h30;
        mst_write_i  = 1'b1;
        mst_wdata_i  = 32'h5555_AAAA;
        mst_wstrb_i  = 4'hF;
        mst_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        mst_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midfwd_reset_ctrl",
                 {slv_valid_o, mst_ready_o, timeout_o, mst_error_o, slv_addr_o, slv_write_o}, 0);
        check_eq("midfwd_reset_wdata", slv_wdata_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_wait[3] = 1; cfg_rdata[3] = 32'h3333_0003; cfg_err[3] = 1'b0;
        run_txn(8'h31, 1'b0, 32'h0, 4'hF);

        // Random traffic including misses and varied waits.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NS; k++) begin
                cfg_wait[k]  = $urandom_range(0, 4);
                cfg_rdata[k] = $urandom;
                cfg_err[k]   = 1'($urandom);
            end
            run_txn(8'($urandom_range(0, 8'h5F)), 1'($urandom), $urandom, 4'($urandom));
        end

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
